user_au_echo: RTL and testbench
===============================

# user_au_echo

Streaming echo/feedback-delay effect stage in the user audio domain. Sits directly downstream of the OBI audio interface: consumes its sign-extended 16-bit sample stream (`data_o`/`valid_o`/`ready_i` side) and produces the processed stream that feeds back into that interface's `data_i`/`valid_i`/`ready_o` side. Keeps a circular buffer of past samples. Each output is the input plus a scaled delayed sample; a scaled copy is written back into the buffer for feedback.

## Interface
- `Depth`, 64: delay-line length in samples; power of two, ≥ 4.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `data_i`, in, 32: input sample, signed, nominally sign-extended 16-bit.
- `valid_i`, in, 1: input sample valid.
- `ready_o`, out, 1: block accepts an input sample.
- `data_o`, out, 32: output sample, signed 16-bit value sign-extended to 32.
- `valid_o`, out, 1: output sample valid.
- `ready_i`, in, 1: downstream accepts the output.
- `delay_len_i`, in, $clog2(Depth): echo delay in samples; 0 is treated as 1.
- `mix_shift_i`, in, 4: wet attenuation, delayed >>> n; 15 = wet path off.
- `fb_shift_i`, in, 4: feedback attenuation, delayed >>> n; 15 = feedback off.
- `bypass_i`, in, 1: output equals input; buffer still written with the input.

## Operation
- FSM states are IDLE, CALC and OUT. Reset state is IDLE.
- **IDLE**
  - `ready_o`=1.
  - On `valid_i`: capture x = sat16(`data_i`) and go to CALC.
- **CALC** (exactly one cycle)
  - Read d = mem[(wptr − D) mod Depth], where D = max(`delay_len_i`, 1).
  - Wet term: m = (`mix_shift_i`==15) ? 0 : d >>> `mix_shift_i` (arithmetic shift).
  - Feedback term: f = (`fb_shift_i`==15) ? 0 : d >>> `fb_shift_i`.
  - Output: y = `bypass_i` ? x : sat16(x + m).
  - Buffer write: mem[wptr] = `bypass_i` ? x : sat16(x + f).
  - wptr += 1, wrapping mod Depth. Register y and go to OUT.
- **OUT**
  - `valid_o`=1, `data_o`={{16{y[15]}}, y}.
  - On `ready_i`: go to IDLE.
- Arithmetic:
  - Sums use 17-bit signed.
  - sat16 clamps to [−32768, 32767].
  - Input capture saturates any 32-bit value to that range.
- Config inputs are sampled only in CALC. Changing them at other times has no effect on the sample in flight.
- Memory: Depth × 16-bit registers, all reset to 0. wptr resets to 0.

## Timing
- Reset values: `ready_o`=0 while `rst_i` is high, 1 in IDLE after release; `valid_o`=0; `data_o`=0.
- Latency: input accepted at edge N → `valid_o`=1 in the cycle after edge N+1, with data valid.
- Minimum 3 cycles per sample: accept, CALC, OUT with `ready_i`=1.
- `ready_o`=0 in CALC and OUT; there is no input skid.
- OUT holds `valid_o` and `data_o` stable until `ready_i`. `valid_o` never drops without a handshake.
- `ready_i` high while not in OUT is ignored.
- `valid_i` is ignored outside IDLE. Upstream must hold its sample; upstream valid pulses that are not held are lost.
- `rst_i` asserted in any state immediately (asynchronously):
  - returns the FSM to IDLE;
  - clears mem, wptr and the output register;
  - drops `valid_o`.
- No combinational path from any input to `ready_o`, `valid_o` or `data_o`.

## Structure
- Shared package `user_au_pkg`:
  - `SampleWidth`=16.
  - Function `sat16` (signed in → saturated 16-bit).
  - Value 15 as the `ShiftOff` constant.
  - FSM state enum `echo_state_e`.
- Sub-module `user_au_delay_line`:
  - Parameter `Depth`.
  - Holds mem and wptr.
  - Ports: `clk_i`, `rst_i`, `delay_len_i`, read data, write enable, write data.
  - Write and pointer advance happen together on write enable.
- Top level holds the FSM, the arithmetic and the output register.

## Test plan
- **Impulse, wet only:** Depth 64, D=4, mix 1, fb 15; inputs 1000, 0×11 → outputs 1000,0,0,0,500,0,0,0,0,0,0,0.
- **Feedback decay:** D=4, mix 0, fb 1; inputs 1000, 0×12 → outputs 1000 then 1000, 500, 250 at indices 4, 8, 12; zeros elsewhere.
- **Saturation:**
  - Input `data_i`=40000 → captured and output 32767.
  - D=1, mix 0: inputs 30000, 30000 → outputs 30000, 32767.
  - Inputs −30000, −30000 → outputs −30000, −32768, with `data_o`=0xFFFF8000.
- **Backpressure:** hold `ready_i`=0 for 5 cycles in OUT → `valid_o` and `data_o` stable, `ready_o`=0, no new sample is accepted; `valid_o` drops the cycle after `ready_i` rises.
- **Wrap-around:** D=63 (and `delay_len_i`=0 → D=1); stream 130 ramp samples → echo of sample k appears at k+63 across the pointer wrap; D=0 behaves as D=1.
- **Reset mid-operation:** assert `rst_i` during CALC and during OUT → `valid_o`=0 at once; after release, `ready_o`=1 and the next impulse sees an all-zero delay line.

Source files
------------

// File: rtl/user_au_pkg.sv
// Shared types and helpers for the user audio-domain effect stages.
package user_au_pkg;

  localparam int SampleWidth = 16;
  localparam logic [3:0] ShiftOff = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } echo_state_e;

  function automatic logic signed [SampleWidth-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[SampleWidth-1:0];
    end
  endfunction

endpackage

// File: rtl/user_au_delay_line.sv
// Circular sample buffer: combinational read D samples behind wptr, write+advance on wr_en_i.
// Latency: read 0 cycles, write lands at the next edge; no backpressure (caller paces writes).
module user_au_delay_line
  import user_au_pkg::*;
#(
  parameter int Depth = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [$clog2(Depth)-1:0]      delay_len_i,
  output logic signed [SampleWidth-1:0] rd_data_o,
  input  logic                          wr_en_i,
  input  logic signed [SampleWidth-1:0] wr_data_i
);

  localparam int AW = $clog2(Depth);

  logic signed [SampleWidth-1:0] mem_q [Depth];
  logic [AW-1:0]                 wptr_q;
  logic [AW-1:0]                 delay_eff;
  logic [AW-1:0]                 rd_addr;

  // A zero delay would read the slot being overwritten; treat it as one sample.
  assign delay_eff = (delay_len_i == '0) ? AW'(1) : delay_len_i;
  assign rd_addr   = wptr_q - delay_eff;
  assign rd_data_o = mem_q[rd_addr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wptr_q] <= wr_data_i;
      wptr_q        <= wptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/user_au_echo.sv
// Echo/feedback-delay stage: y = x + (delayed >>> mix), buffer gets x + (delayed >>> fb).
// Latency: 2 cycles accept-to-valid; one sample in flight, output held until ready_i.
module user_au_echo
  import user_au_pkg::*;
#(
  parameter int Depth = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [31:0]              data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic [$clog2(Depth)-1:0] delay_len_i,
  input  logic [3:0]               mix_shift_i,
  input  logic [3:0]               fb_shift_i,
  input  logic                     bypass_i
);

  echo_state_e state_q, state_d;

  logic signed [SampleWidth-1:0] x_q;
  logic signed [SampleWidth-1:0] y_q;
  logic                          ready_q;

  logic signed [SampleWidth-1:0] delayed;
  logic signed [SampleWidth-1:0] wet;
  logic signed [SampleWidth-1:0] fb;
  logic signed [SampleWidth:0]   sum_wet;
  logic signed [SampleWidth:0]   sum_fb;
  logic signed [SampleWidth-1:0] y_calc;
  logic signed [SampleWidth-1:0] wr_data;
  logic                          accept;

  assign accept = ready_q && valid_i;

  user_au_delay_line #(
    .Depth(Depth)
  ) u_delay_line (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .delay_len_i(delay_len_i),
    .rd_data_o  (delayed),
    .wr_en_i    (state_q == CALC),
    .wr_data_i  (wr_data)
  );

  always_comb begin
    wet = '0;
    fb  = '0;
    if (mix_shift_i != ShiftOff) begin
      wet = delayed >>> mix_shift_i;
    end
    if (fb_shift_i != ShiftOff) begin
      fb = delayed >>> fb_shift_i;
    end
    sum_wet = {x_q[SampleWidth-1], x_q} + {wet[SampleWidth-1], wet};
    sum_fb  = {x_q[SampleWidth-1], x_q} + {fb[SampleWidth-1], fb};
    y_calc  = bypass_i ? x_q : sat16(32'(sum_wet));
    wr_data = bypass_i ? x_q : sat16(32'(sum_fb));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is registered so it stays low through reset and has no input-to-output path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      if (state_q == IDLE && accept) begin
        x_q <= sat16($signed(data_i));
      end
      if (state_q == CALC) begin
        y_q <= y_calc;
      end
    end
  end

  assign ready_o = ready_q;
  assign valid_o = (state_q == OUT);
  assign data_o  = {{16{y_q[SampleWidth-1]}}, y_q};

endmodule

// File: tb/tb_user_au_echo.sv
// Randomized scoreboard bench for user_au_echo against a sample-level reference model.
module tb_user_au_echo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [5:0]  delay_len_i = 6'd4;
  logic [3:0]  mix_shift_i = 4'd15;
  logic [3:0]  fb_shift_i = 4'd15;
  logic        bypass_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_bp  = 1'b0;
  bit rand_rdy = 1'b0;
  bit done     = 1'b0;

  logic [31:0] exp_q[$];
  int          model_mem[64];
  int          model_wp;

  user_au_echo #(.Depth(64)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .delay_len_i(delay_len_i),
    .mix_shift_i(mix_shift_i),
    .fb_shift_i (fb_shift_i),
    .bypass_i   (bypass_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = 0;
    model_wp = 0;
  endfunction

  // One echo step: plain integer arithmetic on a circular array.
  function automatic int model_step(input int raw, input int dl, input int mix, input int fbs, input bit byp);
    int x, d, dd, m, f, y;
    x  = clamp16(raw);
    dd = (dl == 0) ? 1 : dl;
    d  = model_mem[(model_wp - dd + 64) % 64];
    m  = (mix == 15) ? 0 : (d >>> mix);
    f  = (fbs == 15) ? 0 : (d >>> fbs);
    y  = byp ? x : clamp16(x + m);
    model_mem[model_wp] = byp ? x : clamp16(x + f);
    model_wp = (model_wp + 1) % 64;
    return y;
  endfunction

  // ready_i changes at posedge+2 so main-thread control of hold_bp (posedge+1) is ordered.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      ready_i = hold_bp ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: a handshake will occur at the coming posedge when both are high at negedge.
  initial begin
    logic [31:0] e;
    while (!done) begin
      @(negedge clk_i);
      if (!rst_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", data_o, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("sample", data_o, e);
        end
      end
    end
  end

  task automatic send(input int v);
    int cnt;
    int y;
    cnt = 0;
    data_i  = v;
    valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      cnt++;
      if (cnt > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        valid_i = 1'b0;
        return;
      end
    end
    y = model_step(v, int'(delay_len_i), int'(mix_shift_i), int'(fb_shift_i), bypass_i);
    exp_q.push_back(32'(y));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0 && !valid_o) break;
      cnt++;
      if (cnt > 500) begin
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input int dl, input int mix, input int fbs, input bit byp);
    delay_len_i = 6'(dl);
    mix_shift_i = 4'(mix);
    fb_shift_i  = 4'(fbs);
    bypass_i    = byp;
  endtask

  initial begin
    int v;
    model_reset();
    #12;
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("ready_after_rst", {31'd0, ready_o}, 32'd1);

    // Impulse, wet only
    cfg(4, 1, 15, 0);
    send(1000);
    for (int i = 0; i < 11; i++) send(0);
    wait_idle();

    // Feedback decay
    do_reset();
    cfg(4, 0, 1, 0);
    send(1000);
    for (int i = 0; i < 12; i++) send(0);
    wait_idle();

    // Saturation
    do_reset();
    cfg(1, 0, 15, 0);
    send(40000);
    wait_idle();
    do_reset();
    send(30000);
    send(30000);
    wait_idle();
    do_reset();
    send(-30000);
    send(-30000);
    wait_idle();

    // Backpressure: output held, no second sample taken
    do_reset();
    cfg(4, 1, 15, 0);
    hold_bp = 1'b1;
    @(posedge clk_i);
    #1;
    send(1234);
    @(posedge clk_i);
    #1;
    data_i  = 32'd555;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_valid", {31'd0, valid_o}, 32'd1);
      check("bp_data", data_o, 32'd1234);
      check("bp_ready", {31'd0, ready_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    hold_bp = 1'b0;
    @(posedge clk_i);
    #3;
    check("bp_valid_drop", {31'd0, valid_o}, 32'd0);
    wait_idle();

    // Wrap-around with D=63 then D=0
    do_reset();
    rand_rdy = 1'b1;
    cfg(63, 1, 15, 0);
    for (int k = 0; k < 130; k++) send(k * 200 - 13000);
    wait_idle();
    cfg(0, 0, 2, 0);
    for (int k = 0; k < 20; k++) send(k * 1000 - 9000);
    wait_idle();

    // Randomized configs and data, including out-of-range 32-bit inputs
    for (int b = 0; b < 20; b++) begin
      wait_idle();
      cfg($urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7) == 0);
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 5) == 0) v = int'($urandom);
        else v = int'($urandom_range(0, 65535)) - 32768;
        send(v);
      end
    end
    wait_idle();
    rand_rdy = 1'b0;

    // Reset during CALC
    send(777);
    rst_i = 1'b1;
    #1;
    check("rst_calc_valid", {31'd0, valid_o}, 32'd0);
    check("rst_calc_ready", {31'd0, ready_o}, 32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset during OUT
    cfg(4, 0, 15, 0);
    for (int i = 0; i < 6; i++) send(5000 + i);
    wait_idle();
    hold_bp = 1'b1;
    @(posedge clk_i);
    #1;
    send(888);
    @(posedge clk_i);
    #1;
    check("out_before_rst", {31'd0, valid_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, valid_o}, 32'd0);
    check("rst_out_data", data_o, 32'd0);
    exp_q.delete();
    model_reset();
    hold_bp = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("ready_after_midrst", {31'd0, ready_o}, 32'd1);
    send(1000);
    for (int i = 0; i < 8; i++) send(0);
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
